// File: rtl/danmaku_rle_expander.sv
// Expands run-length overlay commands into per-pixel FIFO words and H/V sync markers.
// Optional build macro RLE_FRAME_CHECK_EN adds a per-frame pixel-count check driving frameErr.
module danmaku_rle_expander #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [47:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] fifoData_out,
  output logic        fifoWrreq,
  input  logic        fifoWrFull,
  input  logic [31:0] screenPxl,
  output logic [31:0] pxlCount,
  output logic        badCmd,
  output logic        frameErr
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MARK} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       pxl_q, pxl_d;
  logic              bad_q, bad_d;
  logic [1:0]        cmd_type;
  logic [31:0]       len_ext;
  logic [LEN_W-1:0]  cmd_len;
  logic              unused_ok;

  assign cmd_type  = cmd_data[22:21];
  assign len_ext   = {16'b0, cmd_data[15:0]};
  assign cmd_len   = len_ext[LEN_W-1:0];
  assign unused_ok = ^{cmd_data[20:16], len_ext, screenPxl};

`ifdef RLE_FRAME_CHECK_EN
  logic ferr_q, ferr_d;
  // first VMARK after reset/clr only opens a frame, so it is not checked
  logic first_q, first_d;
  assign frameErr = ferr_q;
`else
  assign frameErr = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    pxl_d     = pxl_q;
    bad_d     = bad_q;
`ifdef RLE_FRAME_CHECK_EN
    ferr_d    = ferr_q;
    first_d   = first_q;
`endif
    cmd_ready = (state_q == S_IDLE) && !clr;
    fifoWrreq = (state_q != S_IDLE) && !fifoWrFull && !clr;
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pxl_d   = '0;
      bad_d   = 1'b0;
`ifdef RLE_FRAME_CHECK_EN
      ferr_d  = 1'b0;
      first_d = 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          case (cmd_type)
            2'b00: if (cmd_len != '0) begin
              data_d  = {cmd_data[47:24], cmd_data[23], 7'b0};
              cnt_d   = cmd_len;
              state_d = S_RUN;
            end
            2'b01: begin
              data_d  = 32'h0000_0001;
              state_d = S_MARK;
            end
            2'b10: begin
              data_d  = 32'h0000_0002;
              state_d = S_MARK;
            end
            default: bad_d = 1'b1;
          endcase
        end
        S_RUN: if (fifoWrreq) begin
          cnt_d = cnt_q - LEN_W'(1);
          pxl_d = pxl_q + 32'd1;
          if (cnt_q == LEN_W'(1)) state_d = S_IDLE;
        end
        S_MARK: if (fifoWrreq) begin
          state_d = S_IDLE;
          if (data_q[1:0] == 2'b10) begin
`ifdef RLE_FRAME_CHECK_EN
            if (!first_q && (pxl_q != screenPxl)) ferr_d = 1'b1;
            first_d = 1'b0;
`endif
            pxl_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      pxl_q   <= '0;
      bad_q   <= 1'b0;
`ifdef RLE_FRAME_CHECK_EN
      ferr_q  <= 1'b0;
      first_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pxl_q   <= pxl_d;
      bad_q   <= bad_d;
`ifdef RLE_FRAME_CHECK_EN
      ferr_q  <= ferr_d;
      first_q <= first_d;
`endif
    end
  end

  assign fifoData_out = data_q;
  assign pxlCount     = pxl_q;
  assign badCmd       = bad_q;

endmodule

// File: tb/tb_danmaku_rle_expander.sv
// Randomized bench for danmaku_rle_expander: a queue of expected FIFO words plus
// frame/pixel bookkeeping is checked against the DUT every cycle.
module tb_danmaku_rle_expander;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [47:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] fifoData_out;
  logic        fifoWrreq;
  logic        fifoWrFull = 1'b0;
  logic [31:0] screenPxl = 32'd6;
  logic [31:0] pxlCount;
  logic        badCmd;
  logic        frameErr;

  danmaku_rle_expander #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .fifoData_out(fifoData_out), .fifoWrreq(fifoWrreq), .fifoWrFull(fifoWrFull),
    .screenPxl(screenPxl), .pxlCount(pxlCount), .badCmd(badCmd), .frameErr(frameErr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
  endtask

  // reference model: words still owed to the FIFO and frame bookkeeping
  logic [31:0] q[$];
  logic [31:0] mpxl  = '0;
  logic        mbad  = 1'b0;
  logic        mferr = 1'b0;
  logic        mfirst = 1'b1;

  always @(negedge clk) begin
    logic [31:0] w;
    logic        exp_wr, exp_rdy;
    if (rst) begin
      exp_rdy = (q.size() == 0) && !clr;
      exp_wr  = (q.size() != 0) && !fifoWrFull && !clr;
      chk("pxlCount", pxlCount, mpxl);
      chk("badCmd", {31'b0, badCmd}, {31'b0, mbad});
      chk("frameErr", {31'b0, frameErr}, {31'b0, mferr});
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_rdy});
      chk("fifoWrreq", {31'b0, fifoWrreq}, {31'b0, exp_wr});
      if (q.size() != 0) chk("fifoData", fifoData_out, q[0]);
      if (clr) begin
        q.delete();
        mpxl = '0; mbad = 1'b0; mferr = 1'b0; mfirst = 1'b1;
      end else begin
        if (exp_wr) begin
          w = q.pop_front();
          if (w[1:0] == 2'b00) mpxl = mpxl + 32'd1;
          else if (w[1:0] == 2'b10) begin
`ifdef RLE_FRAME_CHECK_EN
            if (!mfirst && mpxl != screenPxl) mferr = 1'b1;
            mfirst = 1'b0;
`endif
            mpxl = '0;
          end
        end
        if (exp_rdy && cmd_valid) begin
          case (cmd_data[22:21])
            2'b00: for (int i = 0; i < int'(cmd_data[15:0]); i++)
                     q.push_back({cmd_data[47:24], cmd_data[23], 7'b0});
            2'b01: q.push_back(32'h1);
            2'b10: q.push_back(32'h2);
            default: mbad = 1'b1;
          endcase
        end
      end
    end
  end

  // FIFO-full generator: forced stall cycles take precedence over random stalls
  int force_full = 0;
  bit rnd_full = 1'b0;
  always @(posedge clk) begin
    #1;
    if (force_full > 0) begin
      fifoWrFull = 1'b1;
      force_full--;
    end else begin
      fifoWrFull = rnd_full && ($urandom_range(0, 2) == 0);
    end
  end

  task automatic send(input logic [1:0] typ, input logic [23:0] col, input logic op,
                      input logic [15:0] len);
    bit ok = 1'b0;
    cmd_data  = {col, op, typ, 5'b0, len};
    cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #2;
      if (q.size() == 0) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    int wr_seen;
    bit ok;
    // reset state
    #12;
    chk("rst_data", fifoData_out, 32'h0);
    chk("rst_pxl", pxlCount, 32'h0);
    chk("rst_bad", {31'b0, badCmd}, 32'h0);
    chk("rst_ferr", {31'b0, frameErr}, 32'h0);
    chk("rst_ready", {31'b0, cmd_ready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;

    // basic run
    send(2'b00, 24'hFF0000, 1'b1, 16'd3);
    wait_idle();
    chk("t1_pxl", pxlCount, 32'd3);

    // stall for two cycles right after the first word
    send(2'b00, 24'h12AB34, 1'b0, 16'd4);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (fifoWrreq) ok = 1'b1;
    end
    if (!ok) chk("t2_wr_timeout", 32'd0, 32'd1);
    force_full = 2;
    wait_idle();
    chk("t2_pxl", pxlCount, 32'd7);

    // markers
    send(2'b01, 24'hFFFFFF, 1'b1, 16'd9);
    wait_idle();
    chk("t3_hmark_pxl", pxlCount, 32'd7);
    send(2'b10, 24'h0, 1'b0, 16'd0);
    wait_idle();
    chk("t3_vmark_pxl", pxlCount, 32'd0);

    // empty run and reserved command
    send(2'b00, 24'h00FF00, 1'b1, 16'd0);
    send(2'b11, 24'h0000FF, 1'b1, 16'd5);
    @(negedge clk);
    chk("t4_bad", {31'b0, badCmd}, 32'h1);

    // clr after four words of a ten-word run
    send(2'b00, 24'h445566, 1'b1, 16'd10);
    wr_seen = 0;
    for (int i = 0; i < 50 && wr_seen < 4; i++) begin
      @(negedge clk);
      if (fifoWrreq) wr_seen++;
    end
    pulse_clr();
    chk("t5_pxl", pxlCount, 32'd0);
    chk("t5_bad", {31'b0, badCmd}, 32'h0);
    send(2'b00, 24'h010203, 1'b0, 16'd2);
    wait_idle();
    chk("t5_next_pxl", pxlCount, 32'd2);

    // frame-length check
    pulse_clr();
    screenPxl = 32'd6;
    send(2'b10, 24'h0, 1'b0, 16'd0);
    send(2'b00, 24'hABCDEF, 1'b1, 16'd6);
    send(2'b10, 24'h0, 1'b0, 16'd0);
    wait_idle();
    chk("t6_ferr_ok", {31'b0, frameErr}, 32'h0);
    send(2'b00, 24'hABCDEF, 1'b1, 16'd5);
    send(2'b10, 24'h0, 1'b0, 16'd0);
    wait_idle();
`ifdef RLE_FRAME_CHECK_EN
    chk("t6_ferr_bad", {31'b0, frameErr}, 32'h1);
`else
    chk("t6_ferr_bad", {31'b0, frameErr}, 32'h0);
`endif

    // randomized traffic with random stalls and occasional flushes
    rnd_full = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [1:0] typ;
      int r;
      r = $urandom_range(0, 19);
      typ = (r < 13) ? 2'b00 : (r < 16) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 49) == 0) screenPxl = 32'($urandom_range(3, 12));
      send(typ, 24'($urandom), 1'($urandom), 16'($urandom_range(0, 8)));
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        pulse_clr();
      end
    end
    wait_idle();
    rnd_full = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
